// File: rtl/program_loader_pkg.sv
// Shared byte width and loader FSM encodings for program_loader.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package program_loader_pkg;

  localparam int BYTE_W = 8;
  localparam int LEN_W  = 2 * BYTE_W;

  typedef enum logic [2:0] {
    LD_LEN_HI  = 3'd0,
    LD_LEN_LO  = 3'd1,
    LD_DATA_HI = 3'd2,
    LD_DATA_LO = 3'd3,
    LD_WRITE   = 3'd4,
    LD_CHECK   = 3'd5,
    LD_DONE    = 3'd6,
    LD_ERROR   = 3'd7
  } ld_state_t;

endpackage

// File: rtl/program_loader_if.sv
// Host byte stream, memory write port and CPU control of the program loader.
// Latency: none (wiring only).
// Backpressure: In_Ready from the loader gates In_Valid transfers.
interface program_loader_if
  import program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);

  logic [BYTE_W-1:0]     In_Data;
  logic                  In_Valid;
  logic                  In_Ready;
  logic                  Load_Req;
  logic                  Mem_WE;
  logic [ADDR_WIDTH-1:0] Mem_Addr;
  logic [DATA_WIDTH-1:0] Mem_Data;
  logic                  CPU_Reset;
  logic                  Load_Done;
  logic                  Load_Err;

  // Loader side
  modport master (
    input  In_Data, In_Valid, Load_Req,
    output In_Ready, Mem_WE, Mem_Addr, Mem_Data, CPU_Reset, Load_Done, Load_Err
  );

  // Host / memory / CPU side
  modport slave (
    output In_Data, In_Valid, Load_Req,
    input  In_Ready, Mem_WE, Mem_Addr, Mem_Data, CPU_Reset, Load_Done, Load_Err
  );

endinterface

// File: rtl/program_loader_word_assembler.sv
// Hi-byte latch, big-endian word formation and running XOR checksum (LOADER_CHECKSUM_EN).
// Latency: word_o is combinational from the live lo byte; hi byte and checksum register on accept.
// Backpressure: none; the caller qualifies every strobe with the accepted handshake.
module program_loader_word_assembler
  import program_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              hi_we_i,
  input  logic [BYTE_W-1:0] byte_i,
`ifdef LOADER_CHECKSUM_EN
  input  logic              acc_i,
  output logic [BYTE_W-1:0] chk_o,
`endif
  output logic [LEN_W-1:0]  word_o
);

  logic [BYTE_W-1:0] hi_q, hi_d;

  // Hold the hi byte until its lo partner arrives
  always_comb begin
    hi_d = hi_q;
    if (clear_i)      hi_d = '0;
    else if (hi_we_i) hi_d = byte_i;
  end

  // Hi-byte register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) hi_q <= '0;
    else         hi_q <= hi_d;
  end

  assign word_o = {hi_q, byte_i};

`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] chk_q, chk_d;

  // XOR every data byte in; length and checksum bytes are never strobed
  always_comb begin
    chk_d = chk_q;
    if (clear_i)    chk_d = '0;
    else if (acc_i) chk_d = chk_q ^ byte_i;
  end

  // Checksum register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) chk_q <= '0;
    else         chk_q <= chk_d;
  end

  assign chk_o = chk_q;
`endif

endmodule

// File: rtl/program_loader.sv
// Boot loader: packs host bytes into big-endian words, writes sequential memory, holds CPU until image accepted. Optional checksum: LOADER_CHECKSUM_EN.
// Latency: Mem_WE one cycle after the lo byte is accepted; 2 bytes per 3 cycles peak; CPU_Reset rises one cycle after Load_Done.
// Backpressure: In_Ready low in WRITE, DONE and ERROR; In_Valid low stalls any receiving state indefinitely.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    MAX_WORDS  = 1024
) (
  input  logic             Clock,
  input  logic             Reset,
  program_loader_if.master bus
);

`ifdef LOADER_CHECKSUM_EN
  localparam ld_state_t IMG_END_ST = LD_CHECK;
`else
  localparam ld_state_t IMG_END_ST = LD_DONE;
`endif

  ld_state_t             state_q, state_d;
  logic [BYTE_W-1:0]     len_hi_q, len_hi_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      count_q, count_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  in_rdy;
  logic                  byte_acc;
  logic                  asm_clear;
  logic                  asm_hi_we;
  logic [LEN_W-1:0]      word;
  logic [LEN_W-1:0]      len_w;
`ifdef LOADER_CHECKSUM_EN
  logic                  asm_acc;
  logic [BYTE_W-1:0]     asm_chk;
`endif

  assign byte_acc = bus.In_Valid & in_rdy;
  assign len_w    = {len_hi_q, bus.In_Data};

  program_loader_word_assembler u_asm (
    .clk_i   (Clock),
    .rst_ni  (Reset),
    .clear_i (asm_clear),
    .hi_we_i (asm_hi_we),
    .byte_i  (bus.In_Data),
    .word_o  (word)
`ifdef LOADER_CHECKSUM_EN
    ,
    .acc_i   (asm_acc),
    .chk_o   (asm_chk)
`endif
  );

  // Next state, handshake and write-port control
  always_comb begin
    state_d   = state_q;
    len_hi_d  = len_hi_q;
    len_d     = len_q;
    count_d   = count_q;
    addr_d    = addr_q;
    data_d    = data_q;
    mem_we_d  = 1'b0;
    in_rdy    = 1'b0;
    asm_clear = 1'b0;
    asm_hi_we = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    asm_acc   = 1'b0;
`endif
    case (state_q)
      LD_LEN_HI: begin
        in_rdy = 1'b1;
        if (byte_acc) begin
          len_hi_d = bus.In_Data;
          state_d  = LD_LEN_LO;
        end
      end
      LD_LEN_LO: begin
        in_rdy = 1'b1;
        if (byte_acc) begin
          len_d = len_w;
          // Rejecting oversize images here is what keeps Mem_Addr from wrapping
          if (len_w > LEN_W'(MAX_WORDS)) state_d = LD_ERROR;
          else if (len_w == '0)          state_d = IMG_END_ST;
          else                           state_d = LD_DATA_HI;
        end
      end
      LD_DATA_HI: begin
        in_rdy = 1'b1;
        if (byte_acc) begin
          asm_hi_we = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          asm_acc   = 1'b1;
`endif
          state_d   = LD_DATA_LO;
        end
      end
      LD_DATA_LO: begin
        in_rdy = 1'b1;
        if (byte_acc) begin
`ifdef LOADER_CHECKSUM_EN
          asm_acc  = 1'b1;
`endif
          data_d   = DATA_WIDTH'(word);
          mem_we_d = 1'b1;
          state_d  = LD_WRITE;
        end
      end
      LD_WRITE: begin
        // Memory captures the word at the end of this cycle; step to the next slot
        count_d = count_q + LEN_W'(1);
        addr_d  = addr_q + ADDR_WIDTH'(1);
        state_d = (count_d < len_q) ? LD_DATA_HI : IMG_END_ST;
      end
`ifdef LOADER_CHECKSUM_EN
      LD_CHECK: begin
        in_rdy = 1'b1;
        if (byte_acc) state_d = (bus.In_Data == asm_chk) ? LD_DONE : LD_ERROR;
      end
`endif
      LD_DONE, LD_ERROR: begin
        if (bus.Load_Req) begin
          state_d   = LD_LEN_HI;
          count_d   = '0;
          addr_d    = BASE_ADDR;
          asm_clear = 1'b1;
        end
      end
      default: state_d = LD_LEN_HI;
    endcase
    // Flags track the terminal state; the CPU is released only after a full DONE cycle
    done_d    = (state_d == LD_DONE);
    err_d     = (state_d == LD_ERROR);
    cpu_rst_d = (state_q == LD_DONE) && (state_d == LD_DONE);
  end

  // State and output registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= LD_LEN_HI;
      len_hi_q  <= '0;
      len_q     <= '0;
      count_q   <= '0;
      addr_q    <= BASE_ADDR;
      data_q    <= '0;
      mem_we_q  <= 1'b0;
      cpu_rst_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_hi_q  <= len_hi_d;
      len_q     <= len_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      mem_we_q  <= mem_we_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.In_Ready  = in_rdy;
  assign bus.Mem_WE    = mem_we_q;
  assign bus.Mem_Addr  = addr_q;
  assign bus.Mem_Data  = data_q;
  assign bus.CPU_Reset = cpu_rst_q;
  assign bus.Load_Done = done_q;
  assign bus.Load_Err  = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader; follows LOADER_CHECKSUM_EN when defined.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: every wait on In_Ready or a terminal flag is cycle-bounded.
module tb_program_loader;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  logic [31:0] wr_q[$];
  logic [7:0]  img[$];

  program_loader_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

  program_loader #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (16),
    .BASE_ADDR  (16'h0000),
    .MAX_WORDS  (1024)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  // Record every write strobe as {addr, data}
  always @(negedge Clock)
    if (bus.Mem_WE === 1'b1) wr_q.push_back({bus.Mem_Addr, bus.Mem_Data});

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_we"},   32'(bus.Mem_WE),    0);
    chk({pfx, "_addr"}, 32'(bus.Mem_Addr),  0);
    chk({pfx, "_data"}, 32'(bus.Mem_Data),  0);
    chk({pfx, "_cpu"},  32'(bus.CPU_Reset), 0);
    chk({pfx, "_done"}, 32'(bus.Load_Done), 0);
    chk({pfx, "_err"},  32'(bus.Load_Err),  0);
    chk({pfx, "_rdy"},  32'(bus.In_Ready),  1);
  endtask

  // Called just after a falling edge; returns just after the falling edge following acceptance
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.In_Data  = b;
    bus.In_Valid = 1'b1;
    while (bus.In_Ready !== 1'b1 && n < 40) begin
      @(negedge Clock);
      n++;
    end
    if (bus.In_Ready !== 1'b1) chk("in_ready_timeout", 32'(bus.In_Ready), 1);
    @(negedge Clock);
    bus.In_Valid = 1'b0;
  endtask

  task automatic send_img();
    foreach (img[i]) send_byte(img[i]);
  endtask

  task automatic wait_end();
    int n = 0;
    while (bus.Load_Done !== 1'b1 && bus.Load_Err !== 1'b1 && n < 20) begin
      @(negedge Clock);
      n++;
    end
    if (bus.Load_Done !== 1'b1 && bus.Load_Err !== 1'b1)
      chk("end_timeout", 32'(bus.Load_Done | bus.Load_Err), 1);
  endtask

  task automatic pulse_load_req();
    bus.Load_Req = 1'b1;
    @(negedge Clock);
    bus.Load_Req = 1'b0;
    wr_q.delete();
  endtask

  initial begin
    bus.In_Data  = 8'h00;
    bus.In_Valid = 1'b0;
    bus.Load_Req = 1'b0;
    #2 Reset = 1'b0;
    #1 chk_reset_vals("rst");
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);

    // N=2 back-to-back image
    img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef LOADER_CHECKSUM_EN
    img.push_back(8'h40);
`endif
    send_img();
    wait_end();
    chk("a_done",     32'(bus.Load_Done), 1);
    chk("a_err",      32'(bus.Load_Err),  0);
    chk("a_cpu_held", 32'(bus.CPU_Reset), 0);
    chk("a_nwr",      32'(wr_q.size()),   2);
    chk("a_wr0",      wr_q[0], 32'h0000_1234);
    chk("a_wr1",      wr_q[1], 32'h0001_ABCD);
    @(negedge Clock);
    chk("a_cpu_rel",  32'(bus.CPU_Reset), 1);
    chk("a_addr_end", 32'(bus.Mem_Addr),  2);
    chk("a_rdy_done", 32'(bus.In_Ready),  0);

    // Bytes offered in DONE are refused
    bus.In_Data  = 8'h77;
    bus.In_Valid = 1'b1;
    repeat (3) @(negedge Clock);
    bus.In_Valid = 1'b0;
    chk("done_hold", 32'(bus.Load_Done), 1);
    chk("done_nwr",  32'(wr_q.size()),   2);

    // Reload request clears everything
    pulse_load_req();
    chk("rq_done", 32'(bus.Load_Done), 0);
    chk("rq_cpu",  32'(bus.CPU_Reset), 0);
    chk("rq_addr", 32'(bus.Mem_Addr),  0);
    chk("rq_rdy",  32'(bus.In_Ready),  1);

    // N=1 with In_Valid low every other cycle
    send_byte(8'h00); @(negedge Clock);
    send_byte(8'h01); @(negedge Clock);
    send_byte(8'hBE); @(negedge Clock);
    send_byte(8'hEF);
    chk("t_rdy_write", 32'(bus.In_Ready), 0);
    chk("t_we",        32'(bus.Mem_WE),   1);
    chk("t_wr_addr",   32'(bus.Mem_Addr), 0);
    chk("t_wr_data",   32'(bus.Mem_Data), 32'h0000_BEEF);
`ifdef LOADER_CHECKSUM_EN
    @(negedge Clock);
    send_byte(8'h51);
`endif
    wait_end();
    chk("t_done", 32'(bus.Load_Done), 1);
    chk("t_nwr",  32'(wr_q.size()),   1);
    chk("t_wr0",  wr_q[0], 32'h0000_BEEF);

    // Oversize length 1025
    pulse_load_req();
    img = '{8'h04, 8'h01};
    send_img();
    wait_end();
    chk("e_err",  32'(bus.Load_Err),  1);
    chk("e_done", 32'(bus.Load_Done), 0);
    chk("e_rdy",  32'(bus.In_Ready),  0);
    @(negedge Clock);
    chk("e_cpu",  32'(bus.CPU_Reset), 0);
    chk("e_nwr",  32'(wr_q.size()),   0);

`ifdef LOADER_CHECKSUM_EN
    // Bad checksum, then a good reload
    pulse_load_req();
    img = '{8'h00, 8'h01, 8'h55, 8'hAA, 8'h00};
    send_img();
    wait_end();
    chk("c_bad_err",  32'(bus.Load_Err),  1);
    chk("c_bad_done", 32'(bus.Load_Done), 0);
    pulse_load_req();
    img = '{8'h00, 8'h01, 8'h55, 8'hAA, 8'hFF};
    send_img();
    wait_end();
    chk("c_ok_done", 32'(bus.Load_Done), 1);
    chk("c_ok_err",  32'(bus.Load_Err),  0);
    chk("c_ok_wr0",  wr_q[0], 32'h0000_55AA);
    @(negedge Clock);
    chk("c_ok_cpu",  32'(bus.CPU_Reset), 1);
`endif

    // Empty image
    pulse_load_req();
    img = '{8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    img.push_back(8'h00);
`endif
    send_img();
    wait_end();
    chk("z_done", 32'(bus.Load_Done), 1);
    chk("z_nwr",  32'(wr_q.size()),   0);
    chk("z_addr", 32'(bus.Mem_Addr),  0);

    // Reset after the hi byte of word 3, then a full reload
    pulse_load_req();
    img = '{8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_img();
    chk("m_addr_pre", 32'(bus.Mem_Addr), 2);
    Reset = 1'b0;
    #1 chk_reset_vals("m_rst");
    @(negedge Clock);
    Reset = 1'b1;
    wr_q.delete();
    @(negedge Clock);
    img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef LOADER_CHECKSUM_EN
    img.push_back(8'h40);
`endif
    send_img();
    wait_end();
    chk("r_done", 32'(bus.Load_Done), 1);
    chk("r_nwr",  32'(wr_q.size()),   2);
    chk("r_wr0",  wr_q[0], 32'h0000_1234);
    chk("r_wr1",  wr_q[1], 32'h0001_ABCD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
